dc_motor_cmd_ctrl: RTL and testbench
====================================

// Module: dc_motor_cmd_ctrl
// PURPOSE
//  Command stage that feeds the FND display stage and the H-bridge of the PWM DC-motor design.
//  Takes debounced single-cycle button pulses and maintains a 0..9 duty level and a motor direction.
//  Reversal is safe: ramp down, dead time with the bridge off, then ramp back up in the new direction.
//  Exports duty_cycle/motor_dir for the display and drives pwm_out plus the in1/in2 bridge inputs.
// PARAMETERS
//  PWM_STEP     100_000  clk cycles per PWM slot; PWM period = 10*PWM_STEP (100 Hz at 100 MHz)
//  RAMP_TICKS   5_000_000  clk cycles per 1-step duty change during a ramp (50 ms)
//  DEAD_CYCLES  10_000_000  clk cycles with the bridge off between directions (100 ms)
// PORTS
//  clk         in   1  system clock, 100 MHz
//  reset       in   1  asynchronous, active-low reset
//  btn_up      in   1  1-clk pulse: duty +1
//  btn_down    in   1  1-clk pulse: duty -1
//  btn_dir     in   1  1-clk pulse: request direction reversal
//  duty_cycle  out  4  current applied duty, 0..9 (to the display stage in_data)
//  motor_dir   out  2  01 = forward, 10 = reverse, 00 = stopped (dead time)
//  pwm_out     out  1  registered PWM, high for duty_cycle of the 10 slots
//  in1         out  1  pwm_out when motor_dir==01, else 0
//  in2         out  1  pwm_out when motor_dir==10, else 0
//  busy        out  1  1 while a reversal sequence is in progress
// BEHAVIOUR
//  Reset (async, reset==0): state=RUN, duty_cycle=0, target=0, motor_dir=01, pwm_out/in1/in2/busy=0, all counters=0.
//  The FSM leaves reset on the first clk edge after release.
//  FSM RUN -> RAMP_DN -> DEAD -> RAMP_UP -> RUN. busy=1 in every state except RUN.
//   RUN: btn_up/btn_down update duty_cycle on the next edge (1-clk latency), saturating at 9 and 0.
//        btn_dir: save target=duty_cycle, latch the new direction, go to RAMP_DN.
//   RAMP_DN: every RAMP_TICKS, duty_cycle -1. When duty_cycle==0, go to DEAD.
//        Entry with duty_cycle already 0 goes to DEAD on the next edge.
//   DEAD: motor_dir=00 and in1=in2=0 for exactly DEAD_CYCLES clk cycles.
//        Then motor_dir takes the latched new direction and the FSM goes to RAMP_UP.
//   RAMP_UP: every RAMP_TICKS, duty_cycle +1 until it equals target, then RUN.
//        target==0 returns to RUN on the next edge.
//  During busy: btn_up/btn_down modify target (saturating 0..9); btn_dir is ignored.
//  A target below duty_cycle in RAMP_UP ends the ramp immediately: duty_cycle=target, then RUN.
//  btn_up and btn_down in the same cycle: no change. btn_dir with up/down in RUN: dir wins; up/down apply to target.
//  PWM: slot prescaler 0..PWM_STEP-1 and slot counter 0..9 (wraps 9->0), free-running from reset.
//   pwm_out <= (slot < duty_cycle), registered. duty 0 gives constant 0; duty 9 gives 9/10 high.
//  Ramp tick counter clears on every state entry; the first step occurs RAMP_TICKS cycles after entry.
//  A reset asserted mid-sequence aborts it; outputs return to reset values immediately.
// CONFIGURATION
//  MOTOR_RAMP_EN defined: ramps as described above.
//  MOTOR_RAMP_EN undefined: RAMP_DN sets duty_cycle=0 in one cycle and goes to DEAD.
//   RAMP_UP sets duty_cycle=target in one cycle and goes to RUN.
//   DEAD timing is unchanged; the ramp counter is not synthesised.
// STRUCTURE
//  Package motor_pkg: state encoding (RUN, RAMP_DN, DEAD, RAMP_UP).
//   Also DIR_FWD=2'b01, DIR_REV=2'b10, DIR_STOP=2'b00, DUTY_MAX=4'd9, SLOTS=10.
//  Sub-module motor_pwm_gen: prescaler + slot counter + compare.
//   Ports clk, reset, duty[3:0], pwm; parameter PWM_STEP.
//  The top level holds the FSM, the duty/target registers, and the ramp and dead counters.
// TESTING  (bench parameters: PWM_STEP=2, RAMP_TICKS=4, DEAD_CYCLES=8; MOTOR_RAMP_EN defined unless noted)
//  1. Reset then 12 btn_up pulses -> duty_cycle steps 1..9 and stays 9; 12 btn_down -> 0, no underflow.
//  2. duty=5, measure pwm_out over 20 clks -> exactly 10 high clks; in1 follows pwm_out, in2=0.
//  3. duty=3 fwd, btn_dir -> duty 2,1,0 at 4-clk spacing; motor_dir=00 for 8 clks.
//     Then motor_dir=10, duty 1,2,3 at 4-clk spacing, busy drops; in2 carries PWM.
//  4. During the test-3 dead time: 2 btn_up, 1 btn_dir -> ramp ends at 5, direction unchanged from 10.
//  5. Same-cycle btn_up+btn_down at duty 4 -> stays 4; btn_dir+btn_up at duty 4 -> reversal, final duty 5.
//  6. reset pulled low during RAMP_UP -> duty=0, motor_dir=01, busy=0 within the same cycle.
//     Repeat test 3 with MOTOR_RAMP_EN undefined -> duty 3->0 in 1 clk, 8 dead clks, then 0->3 in 1 clk.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: shared state encoding, direction codes and duty limits for the DC-motor command stage.
//   state_t  : RUN, RAMP_DN, DEAD, RAMP_UP
//   DIR_*    : bridge direction codes as seen on motor_dir
//   sat_step : duty/target +1/-1 with saturation at 0..DUTY_MAX; simultaneous up+down is a no-op
package motor_pkg;
    typedef enum logic [1:0] {RUN, RAMP_DN, DEAD, RAMP_UP} state_t;
    localparam logic [1:0] DIR_FWD  = 2'b01;
    localparam logic [1:0] DIR_REV  = 2'b10;
    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [3:0] DUTY_MAX = 4'd9;
    localparam int SLOTS = 10;
    function automatic logic [3:0] sat_step(input logic [3:0] v, input logic up, input logic dn);
        return (up && !dn && v < DUTY_MAX) ? v + 4'd1 :
               (dn && !up && v != 4'd0)    ? v - 4'd1 : v;
    endfunction
endpackage

// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen: free-running PWM with SLOTS slots of PWM_STEP clocks each.
//   clk   in   system clock
//   reset in   asynchronous active-low reset
//   duty  in   number of high slots per period, 0..9
//   pwm   out  registered PWM, high while slot < duty
module motor_pwm_gen
    import motor_pkg::*;
#(
    parameter int PWM_STEP = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] duty,
    output logic       pwm
);
    localparam int PW = $clog2(PWM_STEP + 1);
    logic [PW-1:0] pre_q;
    logic [3:0]    slot_q;
    logic          pwm_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            slot_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            pwm_q <= slot_q < duty;
            if (pre_q == PW'(PWM_STEP - 1)) begin
                pre_q  <= '0;
                slot_q <= (slot_q == 4'(SLOTS - 1)) ? 4'd0 : slot_q + 4'd1;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end
    assign pwm = pwm_q;
endmodule

// File: rtl/dc_motor_cmd_ctrl.sv
// dc_motor_cmd_ctrl: button-driven duty/direction control with safe ramp-down / dead-time / ramp-up reversal.
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   btn_up     in   1-clk pulse, duty (or target while busy) +1
//   btn_down   in   1-clk pulse, duty (or target while busy) -1
//   btn_dir    in   1-clk pulse, request reversal (ignored while busy)
//   duty_cycle out  applied duty 0..9
//   motor_dir  out  01 fwd, 10 rev, 00 bridge off during dead time
//   pwm_out    out  registered PWM
//   in1/in2    out  PWM steered to the active bridge leg
//   busy       out  reversal sequence in progress
// Build option: MOTOR_RAMP_EN defined ramps duty one step per RAMP_TICKS; undefined jumps in one cycle.
module dc_motor_cmd_ctrl
    import motor_pkg::*;
#(
    parameter int PWM_STEP    = 100_000,
    parameter int RAMP_TICKS  = 5_000_000,
    parameter int DEAD_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_dir,
    output logic [3:0] duty_cycle,
    output logic [1:0] motor_dir,
    output logic       pwm_out,
    output logic       in1,
    output logic       in2,
    output logic       busy
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    state_t        state_q, state_d;
    logic [3:0]    duty_q, duty_d, target_q, target_d;
    logic [1:0]    dir_q, dir_d, new_dir_q, new_dir_d;
    logic [DW-1:0] dead_q, dead_d;
    logic          pwm_q;
`ifdef MOTOR_RAMP_EN
    localparam int RW = $clog2(RAMP_TICKS + 1);
    logic [RW-1:0] ramp_q, ramp_d;
    logic          tick;
    assign tick = ramp_q == RW'(RAMP_TICKS - 1);
    // restarts on every state entry so the first step lands RAMP_TICKS after entry
    assign ramp_d = (state_d == state_q && (state_q == RAMP_DN || state_q == RAMP_UP) && !tick) ?
                    ramp_q + RW'(1) : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ramp_q <= '0;
        else        ramp_q <= ramp_d;
    end
`else
    logic unused_ramp;
    assign unused_ramp = RAMP_TICKS == 0;
`endif
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        target_d  = (state_q == RUN) ? target_q : sat_step(target_q, btn_up, btn_down);
        dir_d     = dir_q;
        new_dir_d = new_dir_q;
        dead_d    = '0;
        case (state_q)
            RUN: begin
                if (btn_dir) begin
                    target_d  = sat_step(duty_q, btn_up, btn_down);
                    new_dir_d = (dir_q == DIR_FWD) ? DIR_REV : DIR_FWD;
                    state_d   = RAMP_DN;
                end else begin
                    duty_d = sat_step(duty_q, btn_up, btn_down);
                end
            end
            RAMP_DN: begin
`ifdef MOTOR_RAMP_EN
                if (duty_q == 4'd0) begin
                    dir_d   = DIR_STOP;
                    state_d = DEAD;
                end else if (tick) begin
                    duty_d = duty_q - 4'd1;
                end
`else
                duty_d  = 4'd0;
                dir_d   = DIR_STOP;
                state_d = DEAD;
`endif
            end
            DEAD: begin
                if (dead_q == DW'(DEAD_CYCLES - 1)) begin
                    dir_d   = new_dir_q;
                    state_d = RAMP_UP;
                end else begin
                    dead_d = dead_q + DW'(1);
                end
            end
            RAMP_UP: begin
`ifdef MOTOR_RAMP_EN
                // a target lowered below the current duty ends the ramp at once
                if (duty_q >= target_q) begin
                    duty_d  = target_q;
                    state_d = RUN;
                end else if (tick) begin
                    duty_d = duty_q + 4'd1;
                end
`else
                duty_d  = target_q;
                state_d = RUN;
`endif
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            duty_q    <= '0;
            target_q  <= '0;
            dir_q     <= DIR_FWD;
            new_dir_q <= DIR_FWD;
            dead_q    <= '0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            dir_q     <= dir_d;
            new_dir_q <= new_dir_d;
            dead_q    <= dead_d;
        end
    end
    motor_pwm_gen #(.PWM_STEP(PWM_STEP)) u_pwm (
        .clk  (clk),
        .reset(reset),
        .duty (duty_q),
        .pwm  (pwm_q)
    );
    assign duty_cycle = duty_q;
    assign motor_dir  = dir_q;
    assign pwm_out    = pwm_q;
    assign in1        = pwm_q && dir_q == DIR_FWD;
    assign in2        = pwm_q && dir_q == DIR_REV;
    assign busy       = state_q != RUN;
endmodule

// File: tb/tb_dc_motor_cmd_ctrl.sv
// tb_dc_motor_cmd_ctrl: table vectors, directed reversal sequences and random stimulus against a behavioural model.
module tb_dc_motor_cmd_ctrl;
    localparam int PS = 2;
    localparam int RT = 4;
    localparam int DC = 8;
`ifdef MOTOR_RAMP_EN
    localparam bit RAMP = 1'b1;
    localparam int FIRST_DEAD = 13, UP_ENTRY = 21, RUN_IDX = 34, DK = 15;
`else
    localparam bit RAMP = 1'b0;
    localparam int FIRST_DEAD = 1, UP_ENTRY = 9, RUN_IDX = 10, DK = 3;
`endif
    localparam int P_RUN = 0, P_DN = 1, P_DEAD = 2, P_UP = 3;

    logic clk = 0, reset = 0, btn_up = 0, btn_down = 0, btn_dir = 0;
    logic [3:0] duty_cycle;
    logic [1:0] motor_dir;
    logic pwm_out, in1, in2, busy;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    dc_motor_cmd_ctrl #(.PWM_STEP(PS), .RAMP_TICKS(RT), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_dir(btn_dir),
        .duty_cycle(duty_cycle), .motor_dir(motor_dir), .pwm_out(pwm_out),
        .in1(in1), .in2(in2), .busy(busy)
    );

    // behavioural model: phase + cycles-since-entry timer, plus absolute edge count for the PWM slot
    int m_duty, m_tgt, m_dir, m_ndir, m_ph, m_t, m_e;
    bit m_pwm;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int sat(input int v, input bit u, input bit d);
        if (u && !d) return (v < 9) ? v + 1 : 9;
        if (d && !u) return (v > 0) ? v - 1 : 0;
        return v;
    endfunction

    task automatic m_reset();
        m_duty = 0; m_tgt = 0; m_dir = 1; m_ndir = 1; m_ph = P_RUN; m_t = 0; m_e = 0; m_pwm = 0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit r);
        int nph = m_ph;
        bit adv = ((m_t + 1) % RT) == 0;
        m_pwm = ((m_e / PS) % 10) < m_duty;
        m_e++;
        case (m_ph)
            P_RUN: begin
                if (r) begin
                    m_tgt = sat(m_duty, u, d);
                    m_ndir = 3 - m_dir;
                    nph = P_DN;
                end else m_duty = sat(m_duty, u, d);
            end
            P_DN: begin
                m_tgt = sat(m_tgt, u, d);
                if (m_duty == 0 || !RAMP) begin
                    m_duty = 0; m_dir = 0; nph = P_DEAD;
                end else if (adv) m_duty--;
            end
            P_DEAD: begin
                m_tgt = sat(m_tgt, u, d);
                if (m_t == DC - 1) begin
                    m_dir = m_ndir; nph = P_UP;
                end
            end
            default: begin
                if (m_duty >= m_tgt || !RAMP) begin
                    m_duty = m_tgt; nph = P_RUN;
                end else if (adv) m_duty++;
                m_tgt = sat(m_tgt, u, d);
            end
        endcase
        m_t = (nph != m_ph) ? 0 : m_t + 1;
        m_ph = nph;
    endtask

    function automatic logic [9:0] dvec();
        return {duty_cycle, motor_dir, pwm_out, in1, in2, busy};
    endfunction

    function automatic logic [9:0] mvec();
        return {4'(m_duty), 2'(m_dir), m_pwm, m_pwm && m_dir == 1, m_pwm && m_dir == 2, m_ph != P_RUN};
    endfunction

    task automatic step(input bit u, input bit d, input bit r);
        btn_up = u; btn_down = d; btn_dir = r;
        @(posedge clk); #1;
        model_step(u, d, r);
        btn_up = 0; btn_down = 0; btn_dir = 0;
        check("model", dvec(), mvec());
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            step(0, 0, 0);
            done = !busy;
        end
        check(name, done, 1);
    endtask

    typedef struct { bit u, d, r; int duty, dir, busy; } vec_t;
    vec_t tbl[30];
    int tr_duty[60], tr_dir[60], tr_busy[60], tr_in1[60], tr_in2[60];

    initial begin
        int hi, c1, c2, nd, fd;
        bit done;
        for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, (i < 9) ? i + 1 : 9, 1, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 9, 1, 0};
        for (int i = 0; i < 12; i++) tbl[13 + i] = '{1'b0, 1'b1, 1'b0, (8 - i > 0) ? 8 - i : 0, 1, 0};
        for (int i = 0; i < 4; i++) tbl[25 + i] = '{1'b1, 1'b0, 1'b0, i + 1, 1, 0};
        tbl[29] = '{1'b1, 1'b1, 1'b0, 4, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_duty", duty_cycle, 0);
        check("rst_dir", motor_dir, 1);
        check("rst_busy", busy, 0);
        check("rst_pwm", {pwm_out, in1, in2}, 0);
        m_reset();
        reset = 1;

        // saturating duty steps, same-cycle up+down
        foreach (tbl[i]) begin
            step(tbl[i].u, tbl[i].d, tbl[i].r);
            check("t1_duty", duty_cycle, tbl[i].duty);
            check("t1_dir", motor_dir, tbl[i].dir);
            check("t1_busy", busy, tbl[i].busy);
        end

        // PWM duty 5 over one full period
        step(1, 0, 0);
        step(0, 0, 0);
        hi = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            hi += int'(pwm_out); c1 += int'(in1); c2 += int'(in2);
        end
        check("t2_pwm_high", hi, 10);
        check("t2_in1_high", c1, 10);
        check("t2_in2_high", c2, 0);

        // reversal from duty 3 forward
        step(0, 1, 0);
        step(0, 1, 0);
        check("t3_start", duty_cycle, 3);
        for (int k = 0; k < 60; k++) begin
            step(0, 0, k == 0);
            tr_duty[k] = duty_cycle; tr_dir[k] = motor_dir; tr_busy[k] = busy;
            tr_in1[k] = in1; tr_in2[k] = in2;
        end
`ifdef MOTOR_RAMP_EN
        check("t3_dn3", tr_duty[3], 3);
        check("t3_dn2", tr_duty[4], 2);
        check("t3_dn1", tr_duty[8], 1);
        check("t3_dn0", tr_duty[12], 0);
        check("t3_up1", tr_duty[25], 1);
        check("t3_up2", tr_duty[29], 2);
        check("t3_up3", tr_duty[33], 3);
`else
        check("t3_jump_dn", tr_duty[1], 0);
        check("t3_up_entry", tr_duty[9], 0);
`endif
        nd = 0; fd = -1;
        for (int k = 0; k < 60; k++) if (tr_dir[k] == 0) begin nd++; if (fd < 0) fd = k; end
        check("t3_dead_len", nd, 8);
        check("t3_dead_first", fd, FIRST_DEAD);
        check("t3_dir_before", tr_dir[UP_ENTRY - 1], 0);
        check("t3_dir_rev", tr_dir[UP_ENTRY], 2);
        check("t3_busy_last", tr_busy[RUN_IDX - 1], 1);
        check("t3_busy_drop", tr_busy[RUN_IDX], 0);
        check("t3_final", tr_duty[RUN_IDX], 3);
        c1 = 0; c2 = 0;
        for (int k = RUN_IDX + 1; k < RUN_IDX + 21; k++) begin c1 += tr_in1[k]; c2 += tr_in2[k]; end
        check("t3_in2_high", c2, 6);
        check("t3_in1_high", c1, 0);

        // during dead time: two ups raise the target, btn_dir is ignored
        done = 0;
        step(0, 0, 1);
        for (int k = 1; k <= 100 && !done; k++) begin
            step(k == DK || k == DK + 1, 0, k == DK + 2);
            done = !busy;
        end
        check("t4_done", done, 1);
        check("t4_duty", duty_cycle, 5);
        check("t4_dir", motor_dir, 1);

        // same-cycle combinations
        step(0, 1, 0);
        check("t5_at4", duty_cycle, 4);
        step(1, 1, 0);
        check("t5_updn", duty_cycle, 4);
        step(1, 0, 1);
        check("t5_dir_wins", busy, 1);
        check("t5_duty_held", duty_cycle, 4);
        wait_idle("t5_done");
        check("t5_duty", duty_cycle, 5);
        check("t5_dir", motor_dir, 2);

        // reset asserted during RAMP_UP
        step(0, 0, 1);
        wait_idle("t6_prep");
        step(0, 0, 1);
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            step(0, 0, 0);
            done = m_ph == P_UP;
        end
        check("t6_reach_up", done, 1);
`ifdef MOTOR_RAMP_EN
        repeat (5) step(0, 0, 0);
        check("t6_mid_duty", duty_cycle, 1);
`endif
        check("t6_mid_dir", motor_dir, 2);
        #2 reset = 0;
        #1;
        check("t6_rst_duty", duty_cycle, 0);
        check("t6_rst_dir", motor_dir, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pwm", pwm_out, 0);
        m_reset();
        reset = 1;

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 60) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
